// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter slice.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DW    = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LOAD  = 2'd2
  } owner_e;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
  parameter int unsigned MAW = 8
) ();

  logic           f_req;
  logic [31:0]    f_addr;
  logic           f_gnt;
  logic           f_rvalid;
  logic [31:0]    f_rdata;
  logic           f_err;

  logic           l_req;
  logic           l_we;
  logic [31:0]    l_addr;
  logic [31:0]    l_wdata;
  logic           l_gnt;
  logic           l_rvalid;
  logic [31:0]    l_rdata;
  logic           l_err;

  logic           m_en;
  logic           m_we;
  logic [MAW-1:0] m_addr;
  logic [31:0]    m_wdata;
  logic [31:0]    m_rdata;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_en, m_we, m_addr, m_wdata
  );

  // Requesters plus memory array side.
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_en, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive loader grants taken while fetch waits.
module imem_starve_ctr #(
  parameter int unsigned LD_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX = 4'(LD_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader priority with bounded
// fetch starvation, address range check, one-cycle response routing.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned MAW    = IMEM_AW,
  parameter int unsigned LD_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  imem_arbiter_if.slave  bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic        at_max;
  logic        l_win;
  logic        f_gnt, l_gnt, any_gnt;
  logic [31:0] sel_addr;
  logic        sel_ok;

  owner_e      owner_q, owner_d;
  logic        oor_q, oor_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  // Grants are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    l_win    = bus.l_req & ~(bus.f_req & at_max);
    l_gnt    = rst_n & l_win;
    f_gnt    = rst_n & bus.f_req & ~l_win;
    any_gnt  = f_gnt | l_gnt;
    sel_addr = l_gnt ? bus.l_addr : bus.f_addr;
    sel_ok   = addr_in_range(sel_addr, DEPTH_W);
  end

  imem_starve_ctr #(
    .LD_MAX (LD_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (l_gnt & bus.f_req),
    .clr    (~bus.f_req | f_gnt),
    .at_max (at_max)
  );

  always_comb begin
    bus.f_gnt   = f_gnt;
    bus.l_gnt   = l_gnt;
    bus.m_en    = any_gnt & sel_ok;
    bus.m_we    = any_gnt & sel_ok & l_gnt & bus.l_we;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (any_gnt && sel_ok) begin
      bus.m_addr  = sel_addr[MAW-1:0];
      bus.m_wdata = bus.l_wdata;
    end
  end

  // Owner of the response that lands next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (f_gnt) begin
      owner_d = OWN_FETCH;
    end else if (l_gnt && !bus.l_we) begin
      owner_d = OWN_LOAD;
    end
    oor_d = any_gnt & ~sel_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      oor_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      oor_q   <= oor_d;
    end
  end

  // Read data passes straight through on the response cycle and is then held.
  always_comb begin
    bus.f_rvalid = (owner_q == OWN_FETCH);
    bus.l_rvalid = (owner_q == OWN_LOAD);
    bus.f_err    = bus.f_rvalid & oor_q;
    bus.l_err    = oor_q & (owner_q != OWN_FETCH);
    f_rdata_d    = f_rdata_q;
    l_rdata_d    = l_rdata_q;
    if (bus.f_rvalid) begin
      f_rdata_d = oor_q ? '0 : bus.m_rdata;
    end
    if (bus.l_rvalid) begin
      l_rdata_d = oor_q ? '0 : bus.m_rdata;
    end
    bus.f_rdata = f_rdata_d;
    bus.l_rdata = l_rdata_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed table, corner sequences and
// randomized traffic against a reference model with its own memory image.
module tb_imem_arbiter;

  localparam int LD_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if #(.MAW(8)) bus ();

  imem_arbiter #(
    .DEPTH  (256),
    .MAW    (8),
    .LD_MAX (LD_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory array: synchronous read, preloaded on the first clock.
  logic [31:0] mem [256];
  bit mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0211_9000 + 32'(i * 16);
      mem_init <= 1'b1;
    end else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model.
  logic [31:0] ref_mem [256];
  int          r_starve;
  logic        e_fg, e_lg, e_men;
  logic        e_fv, e_fe, e_lv, e_le;
  logic [31:0] e_fd, e_ld;

  task automatic model_reset();
    r_starve = 0;
    e_fv = 0; e_fe = 0; e_lv = 0; e_le = 0;
    e_fd = '0; e_ld = '0;
  endtask

  task automatic model_step(input logic fr, input logic [31:0] fa, input logic lr,
                            input logic lw, input logic [31:0] la, input logic [31:0] lwd);
    logic [31:0] a;
    logic ok;
    if (fr && lr) begin
      e_lg = (r_starve != LD_MAX);
      e_fg = !e_lg;
    end else begin
      e_lg = lr;
      e_fg = fr;
    end
    a     = e_lg ? la : fa;
    ok    = (a < 256);
    e_men = (e_fg || e_lg) && ok;
    e_fv  = e_fg;
    e_lv  = e_lg && !lw;
    e_fe  = e_fg && !ok;
    e_le  = e_lg && !ok;
    if (e_fg) e_fd = ok ? ref_mem[a[7:0]] : 32'h0;
    if (e_lv) e_ld = ok ? ref_mem[a[7:0]] : 32'h0;
    if (e_lg && lw && ok) ref_mem[a[7:0]] = lwd;
    if (!fr || e_fg) r_starve = 0;
    else if (e_lg && r_starve < LD_MAX) r_starve++;
  endtask

  // Drive one cycle's inputs (called just after a negedge) and advance the model.
  task automatic apply(input logic fr, input logic [31:0] fa, input logic lr,
                       input logic lw, input logic [31:0] la, input logic [31:0] lwd);
    bus.f_req = fr; bus.f_addr = fa;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = lwd;
    #1;
    model_step(fr, fa, lr, lw, la, lwd);
  endtask

  task automatic chk_model_gnt(input string tag);
    chk({tag, ".f_gnt"}, 32'(bus.f_gnt), 32'(e_fg));
    chk({tag, ".l_gnt"}, 32'(bus.l_gnt), 32'(e_lg));
    chk({tag, ".m_en"},  32'(bus.m_en),  32'(e_men));
  endtask

  task automatic chk_model_resp(input string tag);
    chk({tag, ".f_rvalid"}, 32'(bus.f_rvalid), 32'(e_fv));
    chk({tag, ".f_err"},    32'(bus.f_err),    32'(e_fe));
    chk({tag, ".f_rdata"},  bus.f_rdata,       e_fd);
    chk({tag, ".l_rvalid"}, 32'(bus.l_rvalid), 32'(e_lv));
    chk({tag, ".l_err"},    32'(bus.l_err),    32'(e_le));
    chk({tag, ".l_rdata"},  bus.l_rdata,       e_ld);
  endtask

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr, lw;
    logic [31:0] la, lwd;
    logic        g_f, g_l, men;
    logic        fv, fe;
    logic [31:0] fd;
    logic        lv, le;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [8];
  bit   is_f [12];

  logic        hf, hl, hw;
  logic [31:0] hfa, hla, hwd;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0211_9000 + 32'(i * 16);
    model_reset();

    //        fr fa            lr lw la            lwd           gf gl men fv fe fd            lv le ld
    tbl[0] = '{1, 32'h2,        0, 0, 32'h0,        32'h0,        1, 0, 1,  1, 0, 32'h02119020, 0, 0, 32'h0};
    tbl[1] = '{0, 32'h0,        1, 0, 32'h5,        32'h0,        0, 1, 1,  0, 0, 32'h02119020, 1, 0, 32'h02119050};
    tbl[2] = '{0, 32'h0,        1, 0, 32'h100,      32'h0,        0, 1, 0,  0, 0, 32'h02119020, 1, 1, 32'h0};
    tbl[3] = '{0, 32'h0,        1, 1, 32'h100,      32'h12345678, 0, 1, 0,  0, 0, 32'h02119020, 0, 1, 32'h0};
    tbl[4] = '{0, 32'h0,        1, 1, 32'h11,       32'hCAFEF00D, 0, 1, 1,  0, 0, 32'h02119020, 0, 0, 32'h0};
    tbl[5] = '{1, 32'h11,       0, 0, 32'h0,        32'h0,        1, 0, 1,  1, 0, 32'hCAFEF00D, 0, 0, 32'h0};
    tbl[6] = '{1, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        1, 0, 0,  1, 1, 32'h0,        0, 0, 32'h0};
    tbl[7] = '{1, 32'h3,        1, 0, 32'h7,        32'h0,        0, 1, 1,  0, 0, 32'h0,        1, 0, 32'h02119070};
    is_f = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

    // Reset state with both requests asserted.
    bus.f_req = 1; bus.f_addr = 32'h4; bus.l_req = 1; bus.l_we = 1;
    bus.l_addr = 32'h4; bus.l_wdata = 32'hFFFFFFFF; bus.m_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.f_gnt", 32'(bus.f_gnt), 0);
    chk("rst.l_gnt", 32'(bus.l_gnt), 0);
    chk("rst.m_en",  32'(bus.m_en),  0);
    chk("rst.m_we",  32'(bus.m_we),  0);
    chk("rst.m_wdata", bus.m_wdata, 0);
    chk("rst.f_rvalid", 32'(bus.f_rvalid), 0);
    chk("rst.l_err", 32'(bus.l_err), 0);
    chk("rst.f_rdata", bus.f_rdata, 0);
    rst_n = 1;
    apply(0, 0, 0, 0, 0, 0);

    // Directed table: one access, then an idle cycle.
    for (int i = 0; i < 8; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      @(negedge clk);
      apply(tbl[i].fr, tbl[i].fa, tbl[i].lr, tbl[i].lw, tbl[i].la, tbl[i].lwd);
      chk({t, ".f_gnt"}, 32'(bus.f_gnt), 32'(tbl[i].g_f));
      chk({t, ".l_gnt"}, 32'(bus.l_gnt), 32'(tbl[i].g_l));
      chk({t, ".m_en"},  32'(bus.m_en),  32'(tbl[i].men));
      if (tbl[i].men) chk({t, ".m_addr"}, 32'(bus.m_addr), 32'(tbl[i].g_l ? tbl[i].la[7:0] : tbl[i].fa[7:0]));
      @(negedge clk);
      chk({t, ".f_rvalid"}, 32'(bus.f_rvalid), 32'(tbl[i].fv));
      chk({t, ".f_err"},    32'(bus.f_err),    32'(tbl[i].fe));
      chk({t, ".f_rdata"},  bus.f_rdata,       tbl[i].fd);
      chk({t, ".l_rvalid"}, 32'(bus.l_rvalid), 32'(tbl[i].lv));
      chk({t, ".l_err"},    32'(bus.l_err),    32'(tbl[i].le));
      chk({t, ".l_rdata"},  bus.l_rdata,       tbl[i].ld);
      apply(0, 0, 0, 0, 0, 0);
    end

    // Starvation bound: both requesting for 12 cycles.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("starve%0d.f_rvalid", i), 32'(bus.f_rvalid), 32'(is_f[i-1]));
        chk($sformatf("starve%0d.l_rvalid", i), 32'(bus.l_rvalid), 32'(!is_f[i-1]));
      end
      apply(1, 32'h20 + 32'(i), 1, 0, 32'h40 + 32'(i), 0);
      chk($sformatf("starve%0d.f_gnt", i), 32'(bus.f_gnt), 32'(is_f[i]));
      chk($sformatf("starve%0d.l_gnt", i), 32'(bus.l_gnt), 32'(!is_f[i]));
    end
    @(negedge clk);
    chk("starve.last.l_rdata", bus.l_rdata, 32'h02119000 + 32'((32'h40 + 11) * 16));
    apply(0, 0, 0, 0, 0, 0);

    // Concurrent loader write and fetch to the same address.
    @(negedge clk);
    apply(1, 32'h10, 1, 1, 32'h10, 32'hDEADBEEF);
    chk("wr_rd.l_gnt", 32'(bus.l_gnt), 1);
    chk("wr_rd.f_gnt", 32'(bus.f_gnt), 0);
    chk("wr_rd.m_we",  32'(bus.m_we),  1);
    @(negedge clk);
    chk("wr_rd.no_lrvalid", 32'(bus.l_rvalid), 0);
    apply(1, 32'h10, 0, 0, 0, 0);
    chk("wr_rd.f_gnt2", 32'(bus.f_gnt), 1);
    @(negedge clk);
    chk("wr_rd.f_rvalid", 32'(bus.f_rvalid), 1);
    chk("wr_rd.f_rdata",  bus.f_rdata, 32'hDEADBEEF);
    apply(0, 0, 0, 0, 0, 0);

    // Reset asserted the cycle after a fetch grant.
    @(negedge clk);
    apply(1, 32'h3, 0, 0, 0, 0);
    chk("rmid.f_gnt", 32'(bus.f_gnt), 1);
    @(negedge clk);
    bus.l_req = 1;
    rst_n = 0;
    #1;
    model_reset();
    chk("rmid.f_rvalid", 32'(bus.f_rvalid), 0);
    chk("rmid.f_rdata",  bus.f_rdata, 0);
    chk("rmid.l_rdata",  bus.l_rdata, 0);
    chk("rmid.f_gnt0",   32'(bus.f_gnt), 0);
    chk("rmid.l_gnt0",   32'(bus.l_gnt), 0);
    chk("rmid.m_en",     32'(bus.m_en), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (i <= 1) chk($sformatf("rmid%0d.f_rvalid", i), 32'(bus.f_rvalid), 0);
      apply(1, 32'h8, 1, 0, 32'h9, 0);
      chk($sformatf("rmid%0d.f_gnt", i), 32'(bus.f_gnt), 32'(i == 4));
    end
    @(negedge clk);
    chk_model_resp("rmid.end");
    apply(0, 0, 0, 0, 0, 0);

    // Randomized traffic; requests held until granted.
    hf = 0; hl = 0; hw = 0; hfa = 0; hla = 0; hwd = 0;
    for (int c = 0; c < 400; c++) begin
      logic pf, pl;
      @(negedge clk);
      chk_model_resp($sformatf("rnd%0d", c));
      pf = hf && !bus.f_gnt;
      pl = hl && !bus.l_gnt;
      if (!pf) begin
        hf  = ($urandom_range(0, 3) != 0);
        hfa = ($urandom_range(0, 9) == 0) ? 32'h100 + $urandom_range(0, 4095) : 32'($urandom_range(0, 255));
      end
      if (!pl) begin
        hl  = ($urandom_range(0, 2) != 0);
        hw  = $urandom_range(0, 1) == 1;
        hla = ($urandom_range(0, 9) == 0) ? $urandom() | 32'h100 : 32'($urandom_range(0, 255));
        hwd = $urandom();
      end
      apply(hf, hfa, hl, hw, hla, hwd);
      chk_model_gnt($sformatf("rnd%0d", c));
    end
    @(negedge clk);
    chk_model_resp("rnd.end");
    apply(0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
